// File: rtl/i2c_split_pkg.sv
// Shared definitions for the split-line I2C responder.
//   state_e    : frame state encoding (IDLE, ADDR, DATA, SKIP, DONE)
//   FRAME_BITS : SCLK rising edges per frame (address byte + data byte)
//   ADDR_BITS  : address / data byte width
package i2c_split_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_SKIP = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input with a rising-edge
// pulse derived from the synchronized level.
//   clk     : system clock
//   rst     : synchronous active-high reset (all flops to 0)
//   async_i : asynchronous input
//   level_o : synchronized level (SYNC_STAGES flops deep)
//   rise_o  : one-cycle pulse when level_o goes 0 -> 1
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2c_split_responder.sv
// Responder for the split-line I2C variant (RX in, TX out, SCLK from the
// initiator), running on the local system clock. Receives an 8-bit address
// LSB-first; on a match returns the staged byte LSB-first on TX.
//   CLK, RST    : system clock, synchronous active-high reset
//   SCLK, RX    : asynchronous bus clock and serial address from initiator
//   TX          : serial response data
//   OWN_ADDR    : responder address, used at the address-compare edge
//   DATA_IN/DATA_VALID/DATA_READY : staging-register write handshake
//   RX_ADDR     : last fully received address
//   ADDR_MATCH, FRAME_DONE, FRAME_ERR : one-cycle status pulses
//   BUSY        : high whenever a frame is in progress
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for the first SCLK edge of a frame
// ADDR  | shifting in address bits 1..7
// DATA  | address matched; driving staged byte on TX, edges 8..15
// SKIP  | address did not match; counting edges 8..15 with TX=0
// DONE  | single cycle after edge 15; FRAME_DONE asserted
module i2c_split_responder
  import i2c_split_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SCLK,
  input  logic                 RX,
  output logic                 TX,
  input  logic [ADDR_BITS-1:0] OWN_ADDR,
  input  logic [ADDR_BITS-1:0] DATA_IN,
  input  logic                 DATA_VALID,
  output logic                 DATA_READY,
  output logic [ADDR_BITS-1:0] RX_ADDR,
  output logic                 ADDR_MATCH,
  output logic                 FRAME_DONE,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  localparam logic [3:0]       LAST_ADDR_BIT = 4'(ADDR_BITS - 1);
  localparam logic [3:0]       LAST_BIT      = 4'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD      = CNT_W'(TIMEOUT_CYCLES);

  logic sedge;
  logic rx_s;
  logic rx_rise_unused;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (CLK),
    .rst     (RST),
    .async_i (SCLK),
    .level_o (),
    .rise_o  (sedge)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rx (
    .clk     (CLK),
    .rst     (RST),
    .async_i (RX),
    .level_o (rx_s),
    .rise_o  (rx_rise_unused)
  );

  state_e                 state_q, state_d;
  logic [3:0]             bcnt_q, bcnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [ADDR_BITS-1:0]   rx_addr_q, rx_addr_d;
  logic [ADDR_BITS-1:0]   shift_q, shift_d;
  logic [ADDR_BITS-1:0]   staged_q, staged_d;
  logic                   tx_q, tx_d;
  logic                   match_q, match_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       tmo_q, tmo_d;

  logic                   data_ready;
  logic                   wr;
  logic                   active;
  logic                   timeout;
  logic [ADDR_BITS-1:0]   addr_full;

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    addr_d    = addr_q;
    rx_addr_d = rx_addr_q;
    shift_d   = shift_q;
    staged_d  = staged_q;
    tx_d      = tx_q;
    match_d   = 1'b0;
    err_d     = 1'b0;
    tmo_d     = tmo_q;
    addr_full = addr_q;

    data_ready = (state_q != ST_DATA) && (state_q != ST_DONE);
    wr         = DATA_VALID && data_ready;
    if (wr) staged_d = DATA_IN;

    // Down-counter reloaded on every edge; terminal count 1 with no edge
    // this cycle means TIMEOUT_CYCLES edge-free cycles have elapsed.
    active  = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_SKIP);
    timeout = active && !sedge && (tmo_q == CNT_W'(1));
    if (sedge)       tmo_d = TMO_LOAD;
    else if (active) tmo_d = tmo_q - CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (sedge) begin
          addr_d[0] = rx_s;
          bcnt_d    = 4'd1;
          tx_d      = 1'b0;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (sedge) begin
          addr_full[bcnt_q[2:0]] = rx_s;
          addr_d = addr_full;
          bcnt_d = bcnt_q + 4'd1;
          tx_d   = 1'b0;
          if (bcnt_q == LAST_ADDR_BIT) begin
            rx_addr_d = addr_full;
            if (addr_full == OWN_ADDR) begin
              // A same-cycle write reaches the shifter directly.
              shift_d = wr ? DATA_IN : staged_q;
              match_d = 1'b1;
              state_d = ST_DATA;
            end else begin
              state_d = ST_SKIP;
            end
          end
        end
      end
      ST_DATA: begin
        if (sedge) begin
          // bcnt 8..15 maps to shift bit 0..7 through its low three bits.
          tx_d   = shift_q[bcnt_q[2:0]];
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == LAST_BIT) state_d = ST_DONE;
        end
      end
      ST_SKIP: begin
        if (sedge) begin
          tx_d   = 1'b0;
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == LAST_BIT) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcnt_d  = 4'd0;
        state_d = ST_IDLE;
      end
      default: begin
        bcnt_d  = 4'd0;
        tx_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (timeout) begin
      err_d   = 1'b1;
      bcnt_d  = 4'd0;
      tx_d    = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      bcnt_q    <= 4'd0;
      addr_q    <= '0;
      rx_addr_q <= '0;
      shift_q   <= '0;
      staged_q  <= '0;
      tx_q      <= 1'b0;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      addr_q    <= addr_d;
      rx_addr_q <= rx_addr_d;
      shift_q   <= shift_d;
      staged_q  <= staged_d;
      tx_q      <= tx_d;
      match_q   <= match_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign TX         = tx_q;
  assign DATA_READY = data_ready;
  assign RX_ADDR    = rx_addr_q;
  assign ADDR_MATCH = match_q;
  assign FRAME_DONE = (state_q == ST_DONE);
  assign FRAME_ERR  = err_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule
